batalha_game_ctrl: RTL
======================

Name: batalha_game_ctrl

Overview:
- Game-phase sequencer for the naval-battle board: IDLE, ship positioning, attack, end of game.
- Debounces the confirm button.
- Issues one-cycle load/write/clear strobes to the position and attack matrix registers.
- Decides hit/miss from the position-matrix cell at the selected coordinate.
- Keeps shot and hit counters and drives the status code shown on the 7-segment mux and the LED-matrix source select.

Parameters:
- DEB_CYCLES, 1000000: number of stable cycles the synchronized button must hold before a level is accepted (20 ms at 50 MHz).
- SHIP_CELLS, 6: occupied cells to sink; reaching this count is a win.
- MAX_SHOTS, 20: shot budget; reaching it without a win is a loss (only with SHOT_LIMIT_EN).

Ports:
- clk  in  1  system clock.
- clr  in  1  synchronous active-low reset.
- btn_confirm  in  1  raw confirm push-button, asynchronous, active-high.
- coord  in  6  {row[2:0], col[2:0]} from switches; valid when row<=6 and col<=4.
- pos_cell  in  1  position-matrix bit at coord (combinational lookup outside this block).
- at_cell  in  1  attack-matrix "already shot" bit at coord.
- pos_load  out  1  one-cycle strobe that loads the preset into the position register.
- mat_clr  out  1  one-cycle strobe that clears both matrix registers.
- at_wr  out  1  one-cycle strobe that writes the attack cell.
- at_row  out  3  row of the attack write, registered.
- at_col  out  3  column of the attack write, registered.
- at_hit  out  1  data written with at_wr: 1 = hit, 0 = miss.
- status_code  out  4  value for the 7-segment status digit.
- disp_sel  out  1  LED-matrix source: 0 = position, 1 = attack.
- shots  out  5  shots taken.
- hits  out  4  hits scored.
- game_over  out  1  high in WIN or LOSE.
- win  out  1  high in WIN only.

Behaviour:
- Reset (clr=0 at a clk edge) forces:
  - state IDLE, all strobes 0, at_row/at_col 0, at_hit 0;
  - status_code 0, disp_sel 0, shots 0, hits 0, game_over 0, win 0;
  - synchronizer and debouncer cleared to "released".
- Reset wins over every other event in the same cycle, including mid-game and mid-CHECK.
- Button conditioning:
  - 2-flop synchronizer, then a counter that restarts on any change of the synchronized level.
  - The accepted level updates after DEB_CYCLES stable cycles.
  - press = one-cycle pulse on the accepted 0->1 transition.
  - Latency from a clean raw edge to press: 2+DEB_CYCLES cycles.
  - Release generates nothing.
  - Bounces shorter than DEB_CYCLES generate nothing.
- Every strobe is registered and asserted in the cycle after the qualifying press or state.
- IDLE (status 0, disp_sel 0):
  - press -> mat_clr=1 for 1 cycle, shots=0, hits=0, go to POSITION.
- POSITION (status 1, disp_sel 0):
  - press -> pos_load=1 for 1 cycle, go to ATTACK.
- ATTACK (disp_sel 1, status keeps the last result, 2 on entry). On press:
  - invalid coord -> status 6, no write, stay in ATTACK;
  - valid and at_cell=1 -> status 5 (repeat), no write, no count, stay in ATTACK;
  - valid and at_cell=0 -> latch row/col and pos_cell, go to CHECK.
- CHECK (exactly 1 cycle):
  - at_wr=1, at_hit=latched pos_cell;
  - shots+1;
  - hits+1 if hit;
  - status 3 on hit, 4 on miss.
- Cycle after CHECK, evaluated on the updated counters:
  - hits==SHIP_CELLS -> WIN;
  - else shots==MAX_SHOTS -> LOSE;
  - else ATTACK.
  - A win on the final shot takes priority over the loss.
- WIN: status 7, game_over=1, win=1.
- LOSE: status 8, game_over=1, win=0.
- From WIN or LOSE, press -> IDLE.
- A press that arrives during CHECK or during the post-CHECK cycle is dropped, never queued.
- Counters never wrap:
  - hits saturates at SHIP_CELLS;
  - shots saturates at 31.
- at_row, at_col and at_hit hold their values between writes.

Optional Feature:
- SHOT_LIMIT_EN
- Defined: MAX_SHOTS budget enforced and the LOSE state exists, as described above.
- Undefined: LOSE is never entered, the game ends only by a win, and shots counts up and saturates at 31.

Test Plan:
- Reset and bounce: clr=0 for 3 cycles with DEB_CYCLES=4, then glitch btn_confirm 2 cycles -> all outputs at reset values, no press, state IDLE.
- Clean press from IDLE: hold btn_confirm high for 10 cycles -> mat_clr pulses exactly 1 cycle at 7 cycles (2+DEB_CYCLES+1) after the raw edge; status 1.
- Position then hit: press (pos_load pulse, status 2), then coord={3'd2,3'd1}, pos_cell=1, at_cell=0, press -> at_wr=1 with at_row=2, at_col=1, at_hit=1; shots=1, hits=1, status 3.
- Repeat and invalid shots: coord={3'd7,3'd0} press -> status 6, no at_wr; valid coord with at_cell=1 press -> status 5, shots unchanged.
- Win: SHIP_CELLS=2, two hits -> WIN after the second CHECK, game_over=1, win=1, status 7; next press -> IDLE.
- Loss and priority:
  - With SHOT_LIMIT_EN, MAX_SHOTS=3, three misses -> LOSE, status 8.
  - Final shot both a hit reaching SHIP_CELLS and the MAX_SHOTS-th shot -> WIN.
  - Without the macro, 40 misses -> shots=31, still ATTACK.

Source files
------------

// File: rtl/batalha_game_ctrl.sv
// rtl/batalha_game_ctrl.sv - naval-battle game-phase sequencer with debounced confirm button
//
// Phases: IDLE -> POSITION -> ATTACK <-> CHECK/EVAL -> WIN (or LOSE) -> IDLE.
// Optional feature macro: SHOT_LIMIT_EN (enables the MAX_SHOTS budget and the LOSE state).
//
// Ports:
//   clk, clr            clock, synchronous active-low reset
//   btn_confirm         raw asynchronous confirm button (active-high)
//   coord               {row[2:0], col[2:0]}, valid when row<=6 and col<=4
//   pos_cell, at_cell   position / attack matrix bits at coord
//   pos_load, mat_clr   one-cycle strobes to the matrix registers
//   at_wr, at_row,      one-cycle attack-cell write and its registered address/data
//   at_col, at_hit
//   status_code         7-segment status digit
//   disp_sel            LED-matrix source (0 position, 1 attack)
//   shots, hits         saturating game counters
//   game_over, win      end-of-game flags
module batalha_game_ctrl #(
  parameter int DEB_CYCLES = 1000000,
  parameter int SHIP_CELLS = 6,
  parameter int MAX_SHOTS  = 20
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       btn_confirm,
  input  logic [5:0] coord,
  input  logic       pos_cell,
  input  logic       at_cell,
  output logic       pos_load,
  output logic       mat_clr,
  output logic       at_wr,
  output logic [2:0] at_row,
  output logic [2:0] at_col,
  output logic       at_hit,
  output logic [3:0] status_code,
  output logic       disp_sel,
  output logic [4:0] shots,
  output logic [3:0] hits,
  output logic       game_over,
  output logic       win
);

  localparam int          CW       = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [3:0]  SHIP_L   = 4'(SHIP_CELLS);

  typedef enum logic [2:0] {
    S_IDLE, S_POSITION, S_ATTACK, S_CHECK, S_EVAL, S_WIN, S_LOSE
  } state_t;

  // ---------------- button conditioning ----------------
  logic          sync1_q, sync2_q, deb_q, press_q;
  logic [CW-1:0] cnt_q;

  // The counter only runs while the synchronized level differs from the
  // accepted one; any return to the accepted level restarts it.
  always_ff @(posedge clk) begin
    if (!clr) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_confirm;
      sync2_q <= sync1_q;
      press_q <= 1'b0;
      if (sync2_q != deb_q) begin
        if (cnt_q == DEB_LAST) begin
          deb_q   <= sync2_q;
          press_q <= sync2_q;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  // ---------------- game FSM ----------------
  state_t     state_q, state_d;
  logic [3:0] status_q, status_d;
  logic [4:0] shots_q, shots_d;
  logic [3:0] hits_q, hits_d;
  logic       mat_clr_q, mat_clr_d, pos_load_q, pos_load_d, at_wr_q, at_wr_d;
  logic [2:0] at_row_q, at_row_d, at_col_q, at_col_d;
  logic       at_hit_q, at_hit_d;
  logic [2:0] lat_row_q, lat_row_d, lat_col_q, lat_col_d;
  logic       lat_hit_q, lat_hit_d;
  logic       coord_ok;

  assign coord_ok = (coord[5:3] <= 3'd6) && (coord[2:0] <= 3'd4);

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q    <= S_IDLE;
      status_q   <= 4'd0;
      shots_q    <= 5'd0;
      hits_q     <= 4'd0;
      mat_clr_q  <= 1'b0;
      pos_load_q <= 1'b0;
      at_wr_q    <= 1'b0;
      at_row_q   <= 3'd0;
      at_col_q   <= 3'd0;
      at_hit_q   <= 1'b0;
      lat_row_q  <= 3'd0;
      lat_col_q  <= 3'd0;
      lat_hit_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      status_q   <= status_d;
      shots_q    <= shots_d;
      hits_q     <= hits_d;
      mat_clr_q  <= mat_clr_d;
      pos_load_q <= pos_load_d;
      at_wr_q    <= at_wr_d;
      at_row_q   <= at_row_d;
      at_col_q   <= at_col_d;
      at_hit_q   <= at_hit_d;
      lat_row_q  <= lat_row_d;
      lat_col_q  <= lat_col_d;
      lat_hit_q  <= lat_hit_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    status_d   = status_q;
    shots_d    = shots_q;
    hits_d     = hits_q;
    mat_clr_d  = 1'b0;
    pos_load_d = 1'b0;
    at_wr_d    = 1'b0;
    at_row_d   = at_row_q;
    at_col_d   = at_col_q;
    at_hit_d   = at_hit_q;
    lat_row_d  = lat_row_q;
    lat_col_d  = lat_col_q;
    lat_hit_d  = lat_hit_q;
    unique case (state_q)
      S_IDLE: if (press_q) begin
        mat_clr_d = 1'b1;
        shots_d   = 5'd0;
        hits_d    = 4'd0;
        status_d  = 4'd1;
        state_d   = S_POSITION;
      end
      S_POSITION: if (press_q) begin
        pos_load_d = 1'b1;
        status_d   = 4'd2;
        state_d    = S_ATTACK;
      end
      S_ATTACK: if (press_q) begin
        if (!coord_ok) begin
          status_d = 4'd6;
        end else if (at_cell) begin
          status_d = 4'd5;
        end else begin
          lat_row_d = coord[5:3];
          lat_col_d = coord[2:0];
          lat_hit_d = pos_cell;
          state_d   = S_CHECK;
        end
      end
      S_CHECK: begin
        at_wr_d  = 1'b1;
        at_row_d = lat_row_q;
        at_col_d = lat_col_q;
        at_hit_d = lat_hit_q;
        if (shots_q != 5'd31) shots_d = shots_q + 5'd1;
        if (lat_hit_q && (hits_q < SHIP_L)) hits_d = hits_q + 4'd1;
        status_d = lat_hit_q ? 4'd3 : 4'd4;
        state_d  = S_EVAL;
      end
      // Counters already hold the result of the shot; a win is tested first
      // so a winning final shot beats the exhausted budget.
      S_EVAL: begin
        if (hits_q == SHIP_L) begin
          state_d  = S_WIN;
          status_d = 4'd7;
`ifdef SHOT_LIMIT_EN
        end else if (shots_q == 5'(MAX_SHOTS)) begin
          state_d  = S_LOSE;
          status_d = 4'd8;
`endif
        end else begin
          state_d = S_ATTACK;
        end
      end
      S_WIN, S_LOSE: if (press_q) begin
        status_d = 4'd0;
        state_d  = S_IDLE;
      end
      default: begin
        state_d  = S_IDLE;
        status_d = 4'd0;
      end
    endcase
  end

  assign pos_load    = pos_load_q;
  assign mat_clr     = mat_clr_q;
  assign at_wr       = at_wr_q;
  assign at_row      = at_row_q;
  assign at_col      = at_col_q;
  assign at_hit      = at_hit_q;
  assign status_code = status_q;
  assign disp_sel    = (state_q != S_IDLE) && (state_q != S_POSITION);
  assign shots       = shots_q;
  assign hits        = hits_q;
  assign game_over   = (state_q == S_WIN) || (state_q == S_LOSE);
  assign win         = (state_q == S_WIN);

endmodule
